// File: rtl/logic_unit_pkg.sv
// Shared op-code definitions for the pipelined bitwise logic unit.
package logic_unit_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_INV   = 3'd0;
    localparam logic [OP_W-1:0] OP_NAND2 = 3'd1;
    localparam logic [OP_W-1:0] OP_NAND3 = 3'd2;
    localparam logic [OP_W-1:0] OP_NOR2  = 3'd3;
    localparam logic [OP_W-1:0] OP_NOR3  = 3'd4;
    localparam logic [OP_W-1:0] OP_MUX2  = 3'd5;
    localparam logic [OP_W-1:0] OP_XOR2  = 3'd6;
    localparam logic [OP_W-1:0] OP_PASS  = 3'd7;

endpackage

// File: rtl/logic_unit_fn.sv
// Purely combinational op-selected bitwise function over WIDTH-bit operands.
module logic_unit_fn
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        // NOTE: default assignment first so no path through the block leaves y unassigned (no latch).
        y = a;
        case (op)
            OP_INV:   y = ~a;
            OP_NAND2: y = ~(a & b);
            OP_NAND3: y = ~(a & b & c);
            OP_NOR2:  y = ~(a | b);
            OP_NOR3:  y = ~(a | b | c);
            OP_MUX2:  y = (c & a) | (~c & b);
            OP_XOR2:  y = a ^ b;
            OP_PASS:  y = a;
            default:  y = a;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready pipeline around logic_unit_fn with a saturating result counter.
// Optional registered y_parity output is enabled by defining LOGIC_UNIT_PARITY_EN.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [CNT_W-1:0] op_count
`ifdef LOGIC_UNIT_PARITY_EN
    ,
    output logic             y_parity
`endif
);

    logic             s1_valid_q, s1_valid_d;
    logic [OP_W-1:0]  s1_op_q;
    logic [WIDTH-1:0] s1_a_q, s1_b_q, s1_c_q;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] y_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] fn_y;
    logic             s2_adv, s1_load, s2_load, out_fire;

    // in_ready depends combinationally on out_ready so a full pipe can accept and drain together.
    assign s2_adv   = ~s2_valid_q | out_ready;
    assign in_ready = ~s1_valid_q | s2_adv;
    assign s1_load  = in_valid & in_ready;
    assign s2_load  = s2_adv & s1_valid_q;
    assign out_fire = s2_valid_q & out_ready;

    always_comb begin
        s1_valid_d = in_ready ? in_valid : s1_valid_q;
        s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
        cnt_d      = cnt_q;
        if (out_fire && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    logic_unit_fn #(.WIDTH(WIDTH)) u_fn (
        .op (s1_op_q),
        .a  (s1_a_q),
        .b  (s1_b_q),
        .c  (s1_c_q),
        .y  (fn_y)
    );

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            y_q        <= '0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            cnt_q      <= cnt_d;
            if (s2_load) begin
                y_q <= fn_y;
            end
        end
    end

    // NOTE: S1 operand registers carry no reset; s1_valid_q alone decides whether they mean anything.
    always_ff @(posedge clk) begin
        if (s1_load) begin
            s1_op_q <= op;
            s1_a_q  <= a;
            s1_b_q  <= b;
            s1_c_q  <= c;
        end
    end

`ifdef LOGIC_UNIT_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if (s2_load) begin
            parity_q <= ^fn_y;
        end
    end

    assign y_parity = parity_q;
`endif

    assign out_valid = s2_valid_q;
    assign y         = y_q;
    assign op_count  = cnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: a CNT_W=16 unit plus a CNT_W=3 unit on shared stimulus.
module tb_logic_unit_pipe;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       out_ready;
    logic [2:0] op_i;
    logic [7:0] a_i, b_i, c_i;

    logic        in_ready, out_valid;
    logic [7:0]  y;
    logic [15:0] op_count;
    logic        in_ready_s, out_valid_s;
    logic [7:0]  y_s;
    logic [2:0]  op_count_s;
`ifdef LOGIC_UNIT_PARITY_EN
    logic        y_parity, y_parity_s;
`endif

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    int         model_cnt;
    logic       hold_valid;
    logic [7:0] hold_y;
    logic       accepted;

    logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op_i),
        .a         (a_i),
        .b         (b_i),
        .c         (c_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .op_count  (op_count)
`ifdef LOGIC_UNIT_PARITY_EN
        ,
        .y_parity  (y_parity)
`endif
    );

    logic_unit_pipe #(.WIDTH(8), .CNT_W(3)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_s),
        .op        (op_i),
        .a         (a_i),
        .b         (b_i),
        .c         (c_i),
        .out_valid (out_valid_s),
        .out_ready (out_ready),
        .y         (y_s),
        .op_count  (op_count_s)
`ifdef LOGIC_UNIT_PARITY_EN
        ,
        .y_parity  (y_parity_s)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] model(input logic [2:0] o, input logic [7:0] xa,
                                         input logic [7:0] xb, input logic [7:0] xc);
        case (o)
            3'd0:    return ~xa;
            3'd1:    return ~(xa & xb);
            3'd2:    return ~(xa & xb & xc);
            3'd3:    return ~(xa | xb);
            3'd4:    return ~(xa | xb | xc);
            3'd5:    return (xc & xa) | (~xc & xb);
            3'd6:    return xa ^ xb;
            default: return xa;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard work happens at the negedge, ahead of the edge that performs the transfers.
    task automatic sample();
        logic [7:0] e;
        if (rst) begin
            exp_q.delete();
            model_cnt  = 0;
            hold_valid = 1'b0;
            return;
        end
        check("op_count", op_count, model_cnt);
        check("op_count_sat", op_count_s, (model_cnt > 7) ? 7 : model_cnt);
        if (out_valid) begin
            if (hold_valid) check("y_hold", y, hold_y);
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_output", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("y", y, e);
                    check("y_sat", y_s, e);
                    check("out_valid_sat", out_valid_s, 1'b1);
`ifdef LOGIC_UNIT_PARITY_EN
                    check("y_parity", y_parity, ^e);
                    check("y_parity_sat", y_parity_s, ^e);
`endif
                end
                model_cnt  = model_cnt + 1;
                hold_valid = 1'b0;
            end else begin
                hold_valid = 1'b1;
                hold_y     = y;
            end
        end else begin
            hold_valid = 1'b0;
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(model(op_i, a_i, b_i, c_i));
            accepted = 1'b1;
        end
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] o, input logic [7:0] xa, input logic [7:0] xb,
                        input logic [7:0] xc);
        op_i     = o;
        a_i      = xa;
        b_i      = xb;
        c_i      = xc;
        in_valid = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 20 && !accepted; i++) step();
        check("send_accept", accepted, 1'b1);
        in_valid = 1'b0;
    endtask

    initial begin
        int start_cnt;
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        op_i       = '0;
        a_i        = '0;
        b_i        = '0;
        c_i        = '0;
        model_cnt  = 0;
        hold_valid = 1'b0;
        accepted   = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_in_ready_sat", in_ready_s, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_y", y, 8'h00);
        check("rst_op_count", op_count, 16'd0);
`ifdef LOGIC_UNIT_PARITY_EN
        check("rst_y_parity", y_parity, 1'b0);
`endif

        // Basic ops and two-cycle latency.
        send(3'd2, 8'hFF, 8'hFF, 8'h0F);
        check("lat_n1_out_valid", out_valid, 1'b0);
        step();
        check("lat_n2_out_valid", out_valid, 1'b1);
        check("lat_n2_y", y, model(3'd2, 8'hFF, 8'hFF, 8'h0F));
        send(3'd4, 8'h00, 8'h00, 8'h00);
        step();
        check("nor3_y", y, 8'hFF);
        send(3'd5, 8'hAA, 8'h55, 8'hF0);
        send(3'd6, 8'h3C, 8'h0F, 8'h00);
        send(3'd0, 8'h01, 8'h00, 8'h00);
        step();
        step();
        step();
        check("drain1_out_valid", out_valid, 1'b0);

        // Stall: two accepts fill the pipe, then release.
        out_ready = 1'b0;
        send(3'd1, 8'hF0, 8'h3C, 8'h00);
        send(3'd3, 8'h81, 8'h18, 8'h00);
        check("stall_in_ready", in_ready, 1'b0);
        check("stall_out_valid", out_valid, 1'b1);
        step();
        step();
        check("stall_in_ready_hold", in_ready, 1'b0);
        out_ready = 1'b1;
        check("gap0", out_valid, 1'b1);
        send(3'd7, 8'h5A, 8'h00, 8'h00);
        check("gap1", out_valid, 1'b1);
        send(3'd5, 8'h0F, 8'hF0, 8'h3C);
        check("gap2", out_valid, 1'b1);
        step();
        check("gap3", out_valid, 1'b1);
        step();
        check("stall_drained", out_valid, 1'b0);

        // Full throughput for 10 cycles.
        start_cnt = model_cnt;
        for (int i = 0; i < 10; i++) begin
            send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 8'($urandom));
            check("stream_in_ready", in_ready, 1'b1);
        end
        step();
        step();
        step();
        check("stream_count_delta", op_count - 16'(start_cnt), 16'd10);
        check("sat_hold", op_count_s, 3'd7);

        // Reset with two results pending.
        out_ready = 1'b0;
        send(3'd7, 8'h07, 8'h00, 8'h00);
        send(3'd6, 8'hC3, 8'h11, 8'h00);
        check("pend_y", y, 8'h07);
`ifdef LOGIC_UNIT_PARITY_EN
        check("pend_y_parity", y_parity, 1'b1);
`endif
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_op_count", op_count, 16'd0);
        check("mid_rst_op_count_sat", op_count_s, 3'd0);
        check("mid_rst_in_ready", in_ready, 1'b1);
        check("mid_rst_y", y, 8'h00);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("no_stale_out_valid", out_valid, 1'b0);
        end
        check("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
